// File: rtl/wm_pkg.sv
// Shared definitions for the washing machine controller.
// Holds the Gray-coded program state encoding and the clk_freq select codes.
package wm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_FILL  = 3'b001,
        S_WASH  = 3'b011,
        S_RINSE = 3'b010,
        S_SPIN  = 3'b110,
        S_DONE  = 3'b111
    } state_t;

    // clk_freq select: clock is 1x/2x/4x/8x BASE_DIV cycles per second
    localparam logic [1:0] FREQ_1X = 2'b00;
    localparam logic [1:0] FREQ_2X = 2'b01;
    localparam logic [1:0] FREQ_4X = 2'b10;
    localparam logic [1:0] FREQ_8X = 2'b11;

endpackage

// File: rtl/wm_tick_gen.sv
// Seconds prescaler: emits a one-cycle tick every (BASE_DIV << div_sel) cycles.
// Ports: clk, rst (sync, active-high), div_sel (clk rate select),
//        clear (restart count), freeze (hold count, no tick), tick (out).
module wm_tick_gen
    import wm_pkg::*;
#(
    parameter int BASE_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] div_sel,
    input  logic       clear,
    input  logic       freeze,
    output logic       tick
);

    localparam int DIV_W = $clog2(BASE_DIV * 8);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] term;

    assign term = DIV_W'((BASE_DIV << div_sel) - 1);
    assign tick = !freeze && (cnt == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (cnt == term) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/wash_controller_gen2.sv
// Washing machine program sequencer: FILL/WASH/RINSE loops, then SPIN, DONE.
// Ports: clk, rst (sync, active-high), clk_freq, coin_in, wash_loops,
//        timer_pause, abort in; state, busy, paused, loops_left, wash_done out.
module wash_controller_gen2
    import wm_pkg::*;
#(
    parameter int BASE_DIV  = 1000000,
    parameter int FILL_S    = 120,
    parameter int WASH_S    = 300,
    parameter int RINSE_S   = 120,
    parameter int SPIN_S    = 60,
    parameter int MAX_LOOPS = 3,
    parameter int CYC_W     = $clog2(MAX_LOOPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       clk_freq,
    input  logic             coin_in,
    input  logic [CYC_W-1:0] wash_loops,
    input  logic             timer_pause,
    input  logic             abort,
    output logic [2:0]       state,
    output logic             busy,
    output logic             paused,
    output logic [CYC_W-1:0] loops_left,
    output logic             wash_done
);

    localparam int MAX_A = (FILL_S > WASH_S) ? FILL_S : WASH_S;
    localparam int MAX_B = (RINSE_S > SPIN_S) ? RINSE_S : SPIN_S;
    localparam int MAX_S = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int SEC_W = (MAX_S > 1) ? $clog2(MAX_S) : 1;

    localparam logic [SEC_W-1:0] FILL_L  = SEC_W'(FILL_S - 1);
    localparam logic [SEC_W-1:0] WASH_L  = SEC_W'(WASH_S - 1);
    localparam logic [SEC_W-1:0] RINSE_L = SEC_W'(RINSE_S - 1);
    localparam logic [SEC_W-1:0] SPIN_L  = SEC_W'(SPIN_S - 1);

    localparam logic [CYC_W-1:0] LOOP_ONE = CYC_W'(1);
    localparam logic [CYC_W-1:0] LOOP_MAX = CYC_W'(MAX_LOOPS);

    state_t           state_q;
    state_t           state_n;
    logic [SEC_W-1:0] sec_q;
    logic [SEC_W-1:0] last_sec;
    logic [1:0]       freq_q;
    logic [CYC_W-1:0] loops_q;
    logic [CYC_W-1:0] loops_req;
    logic             busy_q;
    logic             paused_q;
    logic             done_q;
    logic             tick;
    logic             clear;
    logic             freeze;
    logic             phase_end;

    wm_tick_gen #(
        .BASE_DIV(BASE_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .div_sel(freq_q),
        .clear  (clear),
        .freeze (freeze),
        .tick   (tick)
    );

    always_comb begin
        loops_req = wash_loops;
        if (wash_loops == '0) begin
            loops_req = LOOP_ONE;
        end else if (wash_loops > LOOP_MAX) begin
            loops_req = LOOP_MAX;
        end
    end

    always_comb begin
        last_sec = '0;
        unique case (state_q)
            S_FILL:  last_sec = FILL_L;
            S_WASH:  last_sec = WASH_L;
            S_RINSE: last_sec = RINSE_L;
            S_SPIN:  last_sec = SPIN_L;
            default: last_sec = '0;
        endcase
    end

    // IDLE keeps the prescaler parked at zero; pause holds it mid-count
    assign freeze    = (state_q == S_IDLE) || timer_pause;
    assign phase_end = tick && (sec_q == last_sec);

    always_comb begin
        state_n = state_q;
        if (state_q != S_IDLE && abort) begin
            state_n = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (coin_in && !abort) state_n = S_FILL;
                end
                S_FILL: begin
                    if (phase_end) state_n = S_WASH;
                end
                S_WASH: begin
                    if (phase_end) state_n = S_RINSE;
                end
                S_RINSE: begin
                    if (phase_end) begin
                        state_n = (loops_q > LOOP_ONE) ? S_FILL : S_SPIN;
                    end
                end
                S_SPIN: begin
                    if (phase_end) state_n = S_DONE;
                end
                S_DONE: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Every state entry restarts the prescaler and second count
    assign clear = (state_n != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sec_q    <= '0;
            freq_q   <= '0;
            loops_q  <= '0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            busy_q   <= (state_n != S_IDLE);
            paused_q <= (state_q != S_IDLE) && (state_n != S_IDLE)
                        && timer_pause;
            done_q   <= (state_n == S_DONE);

            if (clear) begin
                sec_q <= '0;
            end else if (tick) begin
                sec_q <= sec_q + SEC_W'(1);
            end

            if (state_q == S_IDLE && state_n == S_FILL) begin
                freq_q  <= clk_freq;
                loops_q <= loops_req;
            end else if (state_q == S_RINSE && state_n == S_FILL) begin
                loops_q <= loops_q - LOOP_ONE;
            end else if (state_n == S_IDLE) begin
                freq_q  <= '0;
                loops_q <= '0;
            end
        end
    end

    assign state      = state_q;
    assign busy       = busy_q;
    assign paused     = paused_q;
    assign loops_left = loops_q;
    assign wash_done  = done_q;

endmodule

// File: tb/tb_wash_controller_gen2.sv
// Directed bench for wash_controller_gen2 with short phase timings.
// Each task drives one scenario and compares against hand-computed values.
module tb_wash_controller_gen2;

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_FILL  = 3'b001;
    localparam logic [2:0] ST_WASH  = 3'b011;
    localparam logic [2:0] ST_RINSE = 3'b010;
    localparam logic [2:0] ST_SPIN  = 3'b110;

    logic       clk;
    logic       rst;
    logic [1:0] clk_freq;
    logic       coin_in;
    logic [1:0] wash_loops;
    logic       timer_pause;
    logic       abort;
    logic [2:0] state;
    logic       busy;
    logic       paused;
    logic [1:0] loops_left;
    logic       wash_done;

    int pass_cnt;
    int total_cnt;
    int ph_cnt [8];
    int paused_cnt;
    int loops_seen [$];

    wash_controller_gen2 #(
        .BASE_DIV (4),
        .FILL_S   (2),
        .WASH_S   (5),
        .RINSE_S  (2),
        .SPIN_S   (1),
        .MAX_LOOPS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_freq   (clk_freq),
        .coin_in    (coin_in),
        .wash_loops (wash_loops),
        .timer_pause(timer_pause),
        .abort      (abort),
        .state      (state),
        .busy       (busy),
        .paused     (paused),
        .loops_left (loops_left),
        .wash_done  (wash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic record();
        ph_cnt[state] = ph_cnt[state] + 1;
        if (paused) paused_cnt++;
        if (loops_seen.size() == 0 ||
            loops_seen[loops_seen.size()-1] != int'(loops_left)) begin
            loops_seen.push_back(int'(loops_left));
        end
    endtask

    task automatic coin_start(input logic [1:0] f, input logic [1:0] n);
        clk_freq   = f;
        wash_loops = n;
        coin_in    = 1'b1;
        step();
        coin_in    = 1'b0;
    endtask

    // Called on FILL entry cycle; returns cycles until wash_done or -1
    task automatic run_prog(input int limit, input int p_at, input int p_len,
                            input int chg_at, output int cycles);
        cycles = -1;
        for (int i = 0; i < 8; i++) ph_cnt[i] = 0;
        paused_cnt = 0;
        loops_seen.delete();
        record();
        for (int c = 0; c < limit; c++) begin
            timer_pause = (c >= p_at) && (c < p_at + p_len);
            if (c == chg_at) begin
                clk_freq   = 2'b00;
                wash_loops = 2'b11;
            end
            step();
            if (wash_done) begin
                cycles = c + 1;
                break;
            end
            record();
        end
        timer_pause = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int limit,
                              output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (state == tgt) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total_cnt++;
        if (state !== ST_IDLE) $display("FAIL reset_state got %b want %b", state, ST_IDLE);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (paused !== 1'b0) $display("FAIL reset_paused got %b want 0", paused);
        else pass_cnt++;
        total_cnt++;
        if (loops_left !== 2'd0) $display("FAIL reset_loops got %0d want 0", loops_left);
        else pass_cnt++;
        total_cnt++;
        if (wash_done !== 1'b0) $display("FAIL reset_done got %b want 0", wash_done);
        else pass_cnt++;
    endtask

    task automatic test_single_loop();
        int cyc;
        rst        = 1'b0;
        clk_freq   = 2'b00;
        wash_loops = 2'd1;
        coin_in    = 1'b1;
        step();
        coin_in    = 1'b0;
        total_cnt++;
        if (state !== ST_FILL) $display("FAIL first_coin got %b want %b", state, ST_FILL);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy);
        else pass_cnt++;
        total_cnt++;
        if (loops_left !== 2'd1) $display("FAIL single_loops got %0d want 1", loops_left);
        else pass_cnt++;
        run_prog(200, -1, 0, -1, cyc);
        total_cnt++;
        if (cyc != 40) $display("FAIL single_cycles got %0d want 40", cyc);
        else pass_cnt++;
        total_cnt++;
        if (ph_cnt[ST_FILL] != 8) $display("FAIL single_fill got %0d want 8", ph_cnt[ST_FILL]);
        else pass_cnt++;
        total_cnt++;
        if (ph_cnt[ST_WASH] != 20) $display("FAIL single_wash got %0d want 20", ph_cnt[ST_WASH]);
        else pass_cnt++;
        total_cnt++;
        if (ph_cnt[ST_RINSE] != 8) $display("FAIL single_rinse got %0d want 8", ph_cnt[ST_RINSE]);
        else pass_cnt++;
        total_cnt++;
        if (ph_cnt[ST_SPIN] != 4) $display("FAIL single_spin got %0d want 4", ph_cnt[ST_SPIN]);
        else pass_cnt++;
        step();
        total_cnt++;
        if (wash_done !== 1'b0) $display("FAIL done_pulse got %b want 0", wash_done);
        else pass_cnt++;
        total_cnt++;
        if (state !== ST_IDLE) $display("FAIL done_idle got %b want %b", state, ST_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_multi_loop();
        int cyc;
        coin_start(2'b00, 2'd3);
        run_prog(400, -1, 0, -1, cyc);
        total_cnt++;
        if (cyc != 112) $display("FAIL multi_cycles got %0d want 112", cyc);
        else pass_cnt++;
        total_cnt++;
        if (loops_seen.size() != 3 || loops_seen[0] != 3 ||
            loops_seen[1] != 2 || loops_seen[2] != 1) begin
            $display("FAIL multi_steps got %p want 3,2,1", loops_seen);
        end else pass_cnt++;
        total_cnt++;
        if (ph_cnt[ST_FILL] != 24) $display("FAIL multi_fill got %0d want 24", ph_cnt[ST_FILL]);
        else pass_cnt++;
        step();
        coin_start(2'b00, 2'd0);
        total_cnt++;
        if (loops_left !== 2'd1) $display("FAIL zero_loops got %0d want 1", loops_left);
        else pass_cnt++;
        run_prog(200, -1, 0, -1, cyc);
        total_cnt++;
        if (cyc != 40) $display("FAIL zero_cycles got %0d want 40", cyc);
        else pass_cnt++;
        step();
    endtask

    task automatic test_freq();
        int cyc;
        coin_start(2'b11, 2'd1);
        run_prog(800, -1, 0, 5, cyc);
        total_cnt++;
        if (cyc != 320) $display("FAIL freq8_cycles got %0d want 320", cyc);
        else pass_cnt++;
        total_cnt++;
        if (ph_cnt[ST_WASH] != 160) $display("FAIL freq8_wash got %0d want 160", ph_cnt[ST_WASH]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_pause();
        int cyc;
        coin_start(2'b00, 2'd1);
        run_prog(200, 12, 10, -1, cyc);
        total_cnt++;
        if (cyc != 50) $display("FAIL pause_cycles got %0d want 50", cyc);
        else pass_cnt++;
        total_cnt++;
        if (paused_cnt != 10) $display("FAIL pause_flag got %0d want 10", paused_cnt);
        else pass_cnt++;
        total_cnt++;
        if (ph_cnt[ST_WASH] != 30) $display("FAIL pause_wash got %0d want 30", ph_cnt[ST_WASH]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_abort();
        bit ok;
        coin_start(2'b00, 2'd2);
        wait_state(ST_RINSE, 100, ok);
        total_cnt++;
        if (!ok) $display("FAIL abort_reach got timeout want RINSE");
        else pass_cnt++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total_cnt++;
        if (state !== ST_IDLE) $display("FAIL abort_state got %b want %b", state, ST_IDLE);
        else pass_cnt++;
        total_cnt++;
        if (wash_done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL abort_flags got done=%b busy=%b want 0 0", wash_done, busy);
        end else pass_cnt++;
        total_cnt++;
        if (loops_left !== 2'd0) $display("FAIL abort_loops got %0d want 0", loops_left);
        else pass_cnt++;
        coin_start(2'b00, 2'd1);
        total_cnt++;
        if (state !== ST_FILL) $display("FAIL abort_restart got %b want %b", state, ST_FILL);
        else pass_cnt++;
        abort   = 1'b1;
        coin_in = 1'b1;
        step();
        step();
        total_cnt++;
        if (state !== ST_IDLE) $display("FAIL abort_coin got %b want %b", state, ST_IDLE);
        else pass_cnt++;
        abort   = 1'b0;
        coin_in = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_spin();
        bit ok;
        coin_start(2'b00, 2'd1);
        wait_state(ST_SPIN, 100, ok);
        total_cnt++;
        if (!ok) $display("FAIL spin_reach got timeout want SPIN");
        else pass_cnt++;
        rst = 1'b1;
        step();
        total_cnt++;
        if (state !== ST_IDLE || busy !== 1'b0 || paused !== 1'b0 ||
            loops_left !== 2'd0 || wash_done !== 1'b0) begin
            $display("FAIL rst_spin got st=%b b=%b p=%b l=%0d d=%b want all 0",
                     state, busy, paused, loops_left, wash_done);
        end else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (state !== ST_IDLE) $display("FAIL rst_spin_hold got %b want %b", state, ST_IDLE);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst         = 1'b1;
        clk_freq    = 2'b00;
        coin_in     = 1'b0;
        wash_loops  = 2'd0;
        timer_pause = 1'b0;
        abort       = 1'b0;
        test_reset();
        test_single_loop();
        test_multi_loop();
        test_freq();
        test_pause();
        test_abort();
        test_reset_mid_spin();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
